// File: rtl/ghost_move_controller.sv
`default_nettype none
// ============================================================================
// ghost_move_controller -- every MOVE_PERIOD cycles, steps each ghost one tile
// toward Pacman, falling back clockwise around walls and the grid edge.
// Revision: 1.0
// ============================================================================
module ghost_move_controller #(
   parameter int MOVE_PERIOD = 25000000,
   parameter int NUM_GHOSTS  = 4
) (
   input  logic       clock_50,
   input  logic       reset_n,
   input  logic       start,
   input  logic [4:0] pac_x,
   input  logic [4:0] pac_y,
   output logic [1:0] ghost_sel,
   output logic       reg_en,
   output logic       reg_readwrite,
   output logic [4:0] reg_x_wr,
   output logic [4:0] reg_y_wr,
   input  logic [4:0] reg_x_rd,
   input  logic [4:0] reg_y_rd,
   output logic [4:0] maze_x,
   output logic [4:0] maze_y,
   output logic       maze_rd,
   input  logic       maze_wall,
   output logic       busy,
   output logic       round_done,
   output logic       collision
);
   localparam int                 c_CNT_W      = (MOVE_PERIOD > 1) ? $clog2(MOVE_PERIOD) : 1;
   localparam logic [c_CNT_W-1:0] c_TICK_LAST  = c_CNT_W'(MOVE_PERIOD - 1);
   localparam logic [1:0]         c_LAST_GHOST = 2'(NUM_GHOSTS - 1);
   // Direction codes are ordered so that +1 is a clockwise rotation.
   localparam logic [1:0]         c_UP    = 2'd0;
   localparam logic [1:0]         c_RIGHT = 2'd1;
   localparam logic [1:0]         c_DOWN  = 2'd2;
   localparam logic [1:0]         c_LEFT  = 2'd3;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      WAIT_TICK = 3'd1,
      READ      = 3'd2,
      PROBE     = 3'd3,
      CHECK     = 3'd4,
      WRITE     = 3'd5,
      NEXT      = 3'd6
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic [c_CNT_W-1:0]  r_tick;
   logic [1:0]          r_ghost_sel;
   logic [4:0]          r_gx, r_gy, r_nx, r_ny;
   logic [1:0]          r_dir;
   logic [1:0]          r_tries;
   logic                r_collision;

   logic signed [5:0]   w_dx, w_dy;
   logic [5:0]          w_adx, w_ady;
   logic [1:0]          w_pref;
   logic                w_same;
   logic [4:0]          w_cx, w_cy;
   logic                w_offgrid;
   logic                w_last_try;

   // Direction is chosen from the freshly read coordinates so READ can branch at once.
   assign w_dx   = $signed({1'b0, pac_x}) - $signed({1'b0, reg_x_rd});
   assign w_dy   = $signed({1'b0, pac_y}) - $signed({1'b0, reg_y_rd});
   assign w_adx  = w_dx[5] ? 6'(-w_dx) : 6'(w_dx);
   assign w_ady  = w_dy[5] ? 6'(-w_dy) : 6'(w_dy);
   assign w_pref = (w_adx >= w_ady) ? (w_dx[5] ? c_LEFT : c_RIGHT)
                                    : (w_dy[5] ? c_UP   : c_DOWN);
   assign w_same = (pac_x == reg_x_rd) && (pac_y == reg_y_rd);
   assign w_last_try = (r_tries == 2'd3);

   always_comb begin
      w_cx      = r_gx;
      w_cy      = r_gy;
      w_offgrid = 1'b0;
      case (r_dir)
         c_UP:    begin w_offgrid = (r_gy == 5'd0);  w_cy = r_gy - 5'd1; end
         c_RIGHT: begin w_offgrid = (r_gx == 5'd31); w_cx = r_gx + 5'd1; end
         c_DOWN:  begin w_offgrid = (r_gy == 5'd31); w_cy = r_gy + 5'd1; end
         default: begin w_offgrid = (r_gx == 5'd0);  w_cx = r_gx - 5'd1; end
      endcase
   end

   always_comb begin
      w_next        = r_state;
      reg_en        = 1'b0;
      reg_readwrite = 1'b1;
      reg_x_wr      = 5'd0;
      reg_y_wr      = 5'd0;
      maze_x        = 5'd0;
      maze_y        = 5'd0;
      maze_rd       = 1'b0;
      busy          = 1'b0;
      round_done    = 1'b0;
      case (r_state)
         IDLE: if (start) w_next = WAIT_TICK;
         WAIT_TICK: begin
            if (!start)                    w_next = IDLE;
            else if (r_tick == c_TICK_LAST) w_next = READ;
         end
         READ: begin
            busy   = 1'b1;
            reg_en = 1'b1;
            w_next = w_same ? WRITE : PROBE;
         end
         PROBE: begin
            busy = 1'b1;
            if (w_offgrid) begin
               w_next = w_last_try ? WRITE : PROBE;
            end else begin
               maze_rd = 1'b1;
               maze_x  = w_cx;
               maze_y  = w_cy;
               w_next  = CHECK;
            end
         end
         CHECK: begin
            busy   = 1'b1;
            w_next = (!maze_wall || w_last_try) ? WRITE : PROBE;
         end
         WRITE: begin
            busy          = 1'b1;
            reg_en        = 1'b1;
            reg_readwrite = 1'b0;
            reg_x_wr      = r_nx;
            reg_y_wr      = r_ny;
            w_next        = NEXT;
         end
         NEXT: begin
            busy = 1'b1;
            if (r_ghost_sel < c_LAST_GHOST) begin
               w_next = READ;
            end else begin
               round_done = 1'b1;
               w_next     = start ? WAIT_TICK : IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clock_50) begin
      if (!reset_n) begin
         r_state     <= IDLE;
         r_tick      <= '0;
         r_ghost_sel <= 2'd0;
         r_gx        <= 5'd0;
         r_gy        <= 5'd0;
         r_nx        <= 5'd0;
         r_ny        <= 5'd0;
         r_dir       <= c_UP;
         r_tries     <= 2'd0;
         r_collision <= 1'b0;
      end else begin
         r_state <= w_next;
         r_tick  <= (r_state == WAIT_TICK && w_next == WAIT_TICK) ? r_tick + c_CNT_W'(1) : '0;
         case (r_state)
            WAIT_TICK: if (w_next == READ) r_ghost_sel <= 2'd0;
            READ: begin
               r_gx    <= reg_x_rd;
               r_gy    <= reg_y_rd;
               r_nx    <= reg_x_rd;
               r_ny    <= reg_y_rd;
               r_dir   <= w_pref;
               r_tries <= 2'd0;
               if (w_same) r_collision <= 1'b1;
            end
            PROBE: begin
               if (w_offgrid && !w_last_try) begin
                  r_dir   <= r_dir + 2'd1;
                  r_tries <= r_tries + 2'd1;
               end
            end
            CHECK: begin
               if (!maze_wall) begin
                  r_nx <= w_cx;
                  r_ny <= w_cy;
               end else if (!w_last_try) begin
                  r_dir   <= r_dir + 2'd1;
                  r_tries <= r_tries + 2'd1;
               end
            end
            WRITE: if (r_nx == pac_x && r_ny == pac_y) r_collision <= 1'b1;
            NEXT:  if (w_next == READ) r_ghost_sel <= r_ghost_sel + 2'd1;
            default: ;
         endcase
      end
   end

   assign ghost_sel = r_ghost_sel;
   assign collision = r_collision;

endmodule
`default_nettype wire

// File: tb/tb_ghost_move_controller.sv
`default_nettype none
// Bench for ghost_move_controller: one-ghost vector table, then a four-ghost
// walled round and a reset landing in the middle of a round.
module tb_ghost_move_controller;
   logic clock_50 = 1'b0;
   logic reset_n  = 1'b0;
   always #5 clock_50 = ~clock_50;

   int n_checks = 0;
   int n_err    = 0;
   int cyc      = 0;

   logic [31:0] walls [32];

   // single-ghost instance
   logic       a_start = 1'b0;
   logic [4:0] a_pac_x = '0, a_pac_y = '0;
   logic [1:0] a_ghost_sel;
   logic       a_reg_en, a_reg_rw, a_mrd, a_wall, a_busy, a_done, a_coll;
   logic [4:0] a_x_wr, a_y_wr, a_x_rd, a_y_rd, a_mx, a_my;
   logic [4:0] a_gx_m, a_gy_m;
   logic       a_ld = 1'b0;
   logic [4:0] a_ld_x = '0, a_ld_y = '0;

   // four-ghost instance
   logic       b_start = 1'b0;
   logic [4:0] b_pac_x = '0, b_pac_y = '0;
   logic [1:0] b_ghost_sel;
   logic       b_reg_en, b_reg_rw, b_mrd, b_wall, b_busy, b_done, b_coll;
   logic [4:0] b_x_wr, b_y_wr, b_x_rd, b_y_rd, b_mx, b_my;
   logic [4:0] b_rx [4];
   logic [4:0] b_ry [4];
   logic [4:0] b_ix [4];
   logic [4:0] b_iy [4];
   logic       b_ld = 1'b0;

   ghost_move_controller #(.MOVE_PERIOD(4), .NUM_GHOSTS(1)) dut_a (
      .clock_50(clock_50), .reset_n(reset_n), .start(a_start),
      .pac_x(a_pac_x), .pac_y(a_pac_y), .ghost_sel(a_ghost_sel),
      .reg_en(a_reg_en), .reg_readwrite(a_reg_rw), .reg_x_wr(a_x_wr), .reg_y_wr(a_y_wr),
      .reg_x_rd(a_x_rd), .reg_y_rd(a_y_rd), .maze_x(a_mx), .maze_y(a_my),
      .maze_rd(a_mrd), .maze_wall(a_wall), .busy(a_busy), .round_done(a_done),
      .collision(a_coll));

   ghost_move_controller #(.MOVE_PERIOD(4), .NUM_GHOSTS(4)) dut_b (
      .clock_50(clock_50), .reset_n(reset_n), .start(b_start),
      .pac_x(b_pac_x), .pac_y(b_pac_y), .ghost_sel(b_ghost_sel),
      .reg_en(b_reg_en), .reg_readwrite(b_reg_rw), .reg_x_wr(b_x_wr), .reg_y_wr(b_y_wr),
      .reg_x_rd(b_x_rd), .reg_y_rd(b_y_rd), .maze_x(b_mx), .maze_y(b_my),
      .maze_rd(b_mrd), .maze_wall(b_wall), .busy(b_busy), .round_done(b_done),
      .collision(b_coll));

   // Position registers (combinational read) and a maze RAM with one-cycle read latency.
   assign a_x_rd = a_gx_m;
   assign a_y_rd = a_gy_m;
   assign b_x_rd = b_rx[b_ghost_sel];
   assign b_y_rd = b_ry[b_ghost_sel];

   always @(posedge clock_50) begin
      if (a_ld) begin
         a_gx_m <= a_ld_x;
         a_gy_m <= a_ld_y;
      end else if (a_reg_en && !a_reg_rw) begin
         a_gx_m <= a_x_wr;
         a_gy_m <= a_y_wr;
      end
      a_wall <= a_mrd ? walls[a_my][a_mx] : 1'b0;
      if (b_ld) begin
         for (int i = 0; i < 4; i++) begin
            b_rx[i] <= b_ix[i];
            b_ry[i] <= b_iy[i];
         end
      end else if (b_reg_en && !b_reg_rw) begin
         b_rx[b_ghost_sel] <= b_x_wr;
         b_ry[b_ghost_sel] <= b_y_wr;
      end
      b_wall <= b_mrd ? walls[b_my][b_mx] : 1'b0;
   end

   int         a_read_q[$], a_done_q[$], b_read_q[$], b_done_q[$];
   logic [9:0] a_probe_q[$], a_write_q[$];
   logic [11:0] b_write_q[$];

   always @(negedge clock_50) begin
      cyc = cyc + 1;
      if (a_reg_en && a_reg_rw)  a_read_q.push_back(cyc);
      if (a_reg_en && !a_reg_rw) a_write_q.push_back({a_x_wr, a_y_wr});
      if (a_mrd)                 a_probe_q.push_back({a_mx, a_my});
      if (a_done)                a_done_q.push_back(cyc);
      if (b_reg_en && b_reg_rw)  b_read_q.push_back(cyc);
      if (b_reg_en && !b_reg_rw) b_write_q.push_back({b_ghost_sel, b_x_wr, b_y_wr});
      if (b_done)                b_done_q.push_back(cyc);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   typedef struct {
      int gx, gy, px, py;
      int nw, w0x, w0y, w1x, w1y;
      int do_rst;
      int ex, ey, eprobes, efx, efy, elx, ely, elat, ecoll;
   } vec_t;

   vec_t vt [12];

   task automatic clear_walls();
      for (int y = 0; y < 32; y++) walls[y] = '0;
   endtask

   task automatic run_vec(input int i, input vec_t v);
      int r0, d0, p0, w0;
      if (v.do_rst != 0) begin
         reset_n = 1'b0;
         repeat (2) @(negedge clock_50);
         reset_n = 1'b1;
         chk($sformatf("v%0d_coll_after_reset", i), 32'(a_coll), 0);
      end
      clear_walls();
      if (v.nw > 0) walls[v.w0y][v.w0x] = 1'b1;
      if (v.nw > 1) walls[v.w1y][v.w1x] = 1'b1;
      a_ld_x = 5'(v.gx); a_ld_y = 5'(v.gy); a_ld = 1'b1;
      @(negedge clock_50);
      a_ld = 1'b0;
      a_pac_x = 5'(v.px); a_pac_y = 5'(v.py);
      r0 = a_read_q.size(); d0 = a_done_q.size();
      p0 = a_probe_q.size(); w0 = a_write_q.size();
      a_start = 1'b1;
      for (int k = 0; k < 200 && !a_done; k++) @(negedge clock_50);
      a_start = 1'b0;
      repeat (8) @(negedge clock_50);
      chk($sformatf("v%0d_rounds", i), 32'(a_done_q.size() - d0), 1);
      chk($sformatf("v%0d_writes", i), 32'(a_write_q.size() - w0), 1);
      chk($sformatf("v%0d_probes", i), 32'(a_probe_q.size() - p0), 32'(v.eprobes));
      if (a_write_q.size() > w0)
         chk($sformatf("v%0d_write_xy", i), 32'(a_write_q[w0]), 32'({5'(v.ex), 5'(v.ey)}));
      if (v.eprobes > 0 && a_probe_q.size() > p0) begin
         chk($sformatf("v%0d_first_probe", i), 32'(a_probe_q[p0]), 32'({5'(v.efx), 5'(v.efy)}));
         chk($sformatf("v%0d_last_probe", i), 32'(a_probe_q[a_probe_q.size()-1]),
             32'({5'(v.elx), 5'(v.ely)}));
      end
      if (a_done_q.size() > d0 && a_read_q.size() > r0)
         chk($sformatf("v%0d_latency", i), 32'(a_done_q[d0] - a_read_q[r0] + 1), 32'(v.elat));
      else
         chk($sformatf("v%0d_round_timeout", i), 0, 1);
      chk($sformatf("v%0d_collision", i), 32'(a_coll), 32'(v.ecoll));
      chk($sformatf("v%0d_idle", i), 32'({a_busy, a_ghost_sel}), 0);
   endtask

   initial begin
      int r0, d0, w0, k;
      //        gx  gy  px  py nw w0x w0y w1x w1y rst ex  ey pr efx efy elx ely lat coll
      vt[0]  = '{ 2,  2, 10,  2, 0,  0,  0,  0,  0, 0,  3,  2, 1,  3,  2,  3,  2, 5, 0};
      vt[1]  = '{ 2,  2, 10,  2, 1,  3,  2,  0,  0, 0,  2,  3, 2,  3,  2,  2,  3, 7, 0};
      vt[2]  = '{31,  5, 31, 20, 2, 31,  6, 30,  5, 0, 31,  4, 3, 31,  6, 31,  4, 9, 0};
      vt[3]  = '{ 5, 10,  6,  2, 0,  0,  0,  0,  0, 0,  5,  9, 1,  5,  9,  5,  9, 5, 0};
      vt[4]  = '{ 5,  5,  8,  8, 0,  0,  0,  0,  0, 0,  6,  5, 1,  6,  5,  6,  5, 5, 0};
      vt[5]  = '{ 5,  5,  2,  8, 0,  0,  0,  0,  0, 0,  4,  5, 1,  4,  5,  4,  5, 5, 0};
      vt[6]  = '{ 0,  0,  0,  5, 1,  0,  1,  0,  0, 0,  1,  0, 2,  0,  1,  1,  0, 9, 0};
      vt[7]  = '{ 0,  0,  0,  5, 2,  0,  1,  1,  0, 0,  0,  0, 2,  0,  1,  1,  0, 9, 0};
      vt[8]  = '{31, 31, 20, 31, 1, 30, 31,  0,  0, 0, 31, 30, 2, 30, 31, 31, 30, 7, 0};
      vt[9]  = '{ 3,  3,  4,  3, 0,  0,  0,  0,  0, 0,  4,  3, 1,  4,  3,  4,  3, 5, 1};
      vt[10] = '{ 0,  0,  0,  0, 0,  0,  0,  0,  0, 1,  0,  0, 0,  0,  0,  0,  0, 3, 1};
      vt[11] = '{ 2,  2, 10,  2, 0,  0,  0,  0,  0, 0,  3,  2, 1,  3,  2,  3,  2, 5, 1};

      clear_walls();
      repeat (3) @(negedge clock_50);
      chk("reset_outputs_a", 32'({a_ghost_sel, a_reg_en, a_reg_rw, a_x_wr, a_y_wr, a_mx, a_my,
                                   a_mrd, a_busy, a_done, a_coll}), 32'h100_0000);
      chk("reset_outputs_b", 32'({b_ghost_sel, b_reg_en, b_reg_rw, b_x_wr, b_y_wr, b_mx, b_my,
                                   b_mrd, b_busy, b_done, b_coll}), 32'h100_0000);
      reset_n = 1'b1;
      @(negedge clock_50);

      for (int i = 0; i < 12; i++) run_vec(i, vt[i]);

      // Four ghosts boxed in by walls; start drops right after the round begins.
      clear_walls();
      b_ix = '{5'd5, 5'd10, 5'd15, 5'd20};
      b_iy = '{5'd5, 5'd10, 5'd15, 5'd20};
      for (int i = 0; i < 4; i++) begin
         walls[b_iy[i]][b_ix[i] + 5'd1] = 1'b1;
         walls[b_iy[i]][b_ix[i] - 5'd1] = 1'b1;
         walls[b_iy[i] + 5'd1][b_ix[i]] = 1'b1;
         walls[b_iy[i] - 5'd1][b_ix[i]] = 1'b1;
      end
      b_pac_x = 5'd25; b_pac_y = 5'd25;
      b_ld = 1'b1;
      @(negedge clock_50);
      b_ld = 1'b0;
      r0 = b_read_q.size(); d0 = b_done_q.size(); w0 = b_write_q.size();
      b_start = 1'b1;
      for (k = 0; k < 50 && !(b_reg_en && b_reg_rw); k++) @(negedge clock_50);
      b_start = 1'b0;
      for (k = 0; k < 300 && !b_done; k++) @(negedge clock_50);
      repeat (12) @(negedge clock_50);
      chk("b_writes", 32'(b_write_q.size() - w0), 4);
      for (int i = 0; i < 4; i++)
         if (b_write_q.size() > w0 + i)
            chk($sformatf("b_write%0d", i), 32'(b_write_q[w0 + i]),
                32'({2'(i), b_ix[i], b_iy[i]}));
      chk("b_rounds", 32'(b_done_q.size() - d0), 1);
      chk("b_reads", 32'(b_read_q.size() - r0), 4);
      if (b_done_q.size() > d0 && b_read_q.size() > r0)
         chk("b_round_latency", 32'(b_done_q[d0] - b_read_q[r0] + 1), 44);
      else
         chk("b_round_timeout", 0, 1);
      chk("b_idle_after", 32'({b_busy, b_ghost_sel}), 32'({1'b0, 2'd3}));

      // Reset lands in the CHECK cycle of ghost 2 while start stays high.
      w0 = b_write_q.size();
      b_start = 1'b1;
      for (k = 0; k < 300 && !(b_mrd && b_ghost_sel == 2'd2); k++) @(negedge clock_50);
      chk("b_reach_ghost2_probe", 32'(k < 300), 1);
      @(negedge clock_50);
      reset_n = 1'b0;
      @(negedge clock_50);
      chk("b_reset_mid_round", 32'({b_ghost_sel, b_reg_en, b_reg_rw, b_x_wr, b_y_wr, b_mx, b_my,
                                    b_mrd, b_busy, b_done, b_coll}), 32'h100_0000);
      reset_n = 1'b1;
      for (k = 1; k < 20; k++) begin
         @(negedge clock_50);
         if (b_reg_en) break;
      end
      chk("b_release_to_read", 32'(k), 5);
      chk("b_read_after_release", 32'({b_reg_rw, b_ghost_sel}), 32'({1'b1, 2'd0}));
      chk("b_writes_before_reset", 32'(b_write_q.size() - w0), 2);
      b_start = 1'b0;
      for (k = 0; k < 300 && !b_done; k++) @(negedge clock_50);
      repeat (4) @(negedge clock_50);
      chk("b_final_idle", 32'(b_busy), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout: got no end expected end");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
